// File: rtl/uart_mem_bridge.sv
// Bridges one-shot UART monitor read/write requests onto a single-master memory port.
// Optional ack timeout is enabled with the BRIDGE_TIMEOUT_EN macro.
module uart_mem_bridge #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        u_read_req,
  input  logic        u_read_w,
  input  logic [31:0] u_read_adr,
  output logic        read_valid,
  output logic [31:0] read_data,
  input  logic        u_write_req,
  input  logic        u_write_w,
  input  logic [31:0] u_write_adr,
  input  logic [31:0] u_write_data,
  output logic        write_finish,
  input  logic        cpu_busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_isel,
  output logic [29:0] mem_adr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        req_ovr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;

  logic        rd_vld_q, rd_vld_d;
  logic        rd_isel_q, rd_isel_d;
  logic [29:0] rd_adr_q, rd_adr_d;

  logic        wr_vld_q, wr_vld_d;
  logic        wr_isel_q, wr_isel_d;
  logic [29:0] wr_adr_q, wr_adr_d;
  logic [31:0] wr_data_q, wr_data_d;

  logic        mem_we_q, mem_we_d;
  logic        mem_isel_q, mem_isel_d;
  logic [29:0] mem_adr_q, mem_adr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] read_data_q, read_data_d;
  logic        req_ovr_q, req_ovr_d;

  logic        wait_end;
  logic        timed_out;

`ifdef BRIDGE_TIMEOUT_EN
  logic [15:0] to_cnt_q, to_cnt_d;

  // Counts completed WAIT cycles; the last one is cycle TIMEOUT_CYC.
  always_comb begin
    to_cnt_d  = '0;
    timed_out = 1'b0;
    if (state_q == WAIT && !mem_ack) begin
      if (to_cnt_q == 16'(TIMEOUT_CYC - 1)) begin
        timed_out = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{u_read_adr[1:0], u_write_adr[1:0]};
`else
  assign timed_out = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{u_read_adr[1:0], u_write_adr[1:0], 32'(TIMEOUT_CYC)};
`endif

  assign wait_end = (state_q == WAIT) && (mem_ack || timed_out);

  // Request slots and overrun flag.
  always_comb begin
    rd_vld_d  = rd_vld_q;
    rd_isel_d = rd_isel_q;
    rd_adr_d  = rd_adr_q;
    wr_vld_d  = wr_vld_q;
    wr_isel_d = wr_isel_q;
    wr_adr_d  = wr_adr_q;
    wr_data_d = wr_data_q;
    req_ovr_d = req_ovr_q;

    if (wait_end) begin
      if (mem_we_q) begin
        wr_vld_d = 1'b0;
      end else begin
        rd_vld_d = 1'b0;
      end
    end

    if (u_read_req) begin
      if (rd_vld_q) begin
        req_ovr_d = 1'b1;
      end else begin
        rd_vld_d  = 1'b1;
        rd_isel_d = u_read_w;
        rd_adr_d  = u_read_adr[31:2];
      end
    end

    if (u_write_req) begin
      if (wr_vld_q) begin
        req_ovr_d = 1'b1;
      end else begin
        wr_vld_d  = 1'b1;
        wr_isel_d = u_write_w;
        wr_adr_d  = u_write_adr[31:2];
        wr_data_d = u_write_data;
      end
    end
  end

  // Next state and registered memory-side controls.
  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_isel_d  = mem_isel_q;
    mem_adr_d   = mem_adr_q;
    mem_wdata_d = mem_wdata_q;
    read_data_d = read_data_q;

    unique case (state_q)
      IDLE: begin
        if (!cpu_busy) begin
          if (wr_vld_q) begin
            state_d     = ISSUE;
            mem_we_d    = 1'b1;
            mem_isel_d  = wr_isel_q;
            mem_adr_d   = wr_adr_q;
            mem_wdata_d = wr_data_q;
          end else if (rd_vld_q) begin
            state_d    = ISSUE;
            mem_we_d   = 1'b0;
            mem_isel_d = rd_isel_q;
            mem_adr_d  = rd_adr_q;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (wait_end) begin
          state_d = DONE;
          if (!mem_we_q) begin
            read_data_d = mem_ack ? mem_rdata : 32'hDEAD_BEEF;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_vld_q    <= 1'b0;
      rd_isel_q   <= 1'b0;
      rd_adr_q    <= '0;
      wr_vld_q    <= 1'b0;
      wr_isel_q   <= 1'b0;
      wr_adr_q    <= '0;
      wr_data_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_isel_q  <= 1'b0;
      mem_adr_q   <= '0;
      mem_wdata_q <= '0;
      read_data_q <= '0;
      req_ovr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_vld_q    <= rd_vld_d;
      rd_isel_q   <= rd_isel_d;
      rd_adr_q    <= rd_adr_d;
      wr_vld_q    <= wr_vld_d;
      wr_isel_q   <= wr_isel_d;
      wr_adr_q    <= wr_adr_d;
      wr_data_q   <= wr_data_d;
      mem_we_q    <= mem_we_d;
      mem_isel_q  <= mem_isel_d;
      mem_adr_q   <= mem_adr_d;
      mem_wdata_q <= mem_wdata_d;
      read_data_q <= read_data_d;
      req_ovr_q   <= req_ovr_d;
    end
  end

  // mem_req decodes straight from state so an async reset removes it at once.
  assign mem_req      = (state_q == ISSUE) || (state_q == WAIT);
  assign mem_we       = mem_we_q;
  assign mem_isel     = mem_isel_q;
  assign mem_adr      = mem_adr_q;
  assign mem_wdata    = mem_wdata_q;
  assign read_data    = read_data_q;
  assign req_ovr      = req_ovr_q;
  assign read_valid   = (state_q == DONE) && !mem_we_q;
  assign write_finish = (state_q == DONE) && mem_we_q;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed self-checking bench for uart_mem_bridge.
module tb_uart_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        u_read_req, u_read_w;
  logic [31:0] u_read_adr;
  logic        read_valid;
  logic [31:0] read_data;
  logic        u_write_req, u_write_w;
  logic [31:0] u_write_adr, u_write_data;
  logic        write_finish;
  logic        cpu_busy;
  logic        mem_req, mem_we, mem_isel;
  logic [29:0] mem_adr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        req_ovr;

  int n_checks = 0;
  int n_fail   = 0;

  uart_mem_bridge #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .u_read_req(u_read_req), .u_read_w(u_read_w), .u_read_adr(u_read_adr),
    .read_valid(read_valid), .read_data(read_data),
    .u_write_req(u_write_req), .u_write_w(u_write_w), .u_write_adr(u_write_adr),
    .u_write_data(u_write_data), .write_finish(write_finish),
    .cpu_busy(cpu_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_isel(mem_isel), .mem_adr(mem_adr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .req_ovr(req_ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return mem_req;
      1:       return read_valid;
      default: return write_finish;
    endcase
  endfunction

  // Returns at the first sample where the selected output is high.
  task automatic wait_sig(input int sel, input int budget, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sig(sel)) begin
        seen = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic pulse_rd(input logic w, input logic [31:0] adr);
    u_read_req = 1'b1; u_read_w = w; u_read_adr = adr;
    tick();
    u_read_req = 1'b0;
  endtask

  task automatic ack(input logic [31:0] d);
    mem_ack = 1'b1; mem_rdata = d;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  logic seen;
  int   cnt;

  initial begin
    rst = 1'b1;
    u_read_req = 0; u_read_w = 0; u_read_adr = '0;
    u_write_req = 0; u_write_w = 0; u_write_adr = '0; u_write_data = '0;
    cpu_busy = 0; mem_ack = 0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    check("rst_mem_req", mem_req, 0);
    check("rst_read_valid", read_valid, 0);
    check("rst_write_finish", write_finish, 0);
    check("rst_req_ovr", req_ovr, 0);
    check("rst_read_data", read_data, 0);
    check("rst_mem_adr", mem_adr, 0);

    // Data read, ack on the 3rd WAIT cycle; ack while idle must be ignored.
    ack(32'h5555_AAAA);
    check("idle_ack_no_req", mem_req, 0);
    check("idle_ack_no_valid", read_valid, 0);
    pulse_rd(1'b0, 32'h0000_0010);
    check("rd_lat_not_yet", mem_req, 0);
    tick();
    check("rd_lat_2clk", mem_req, 1);
    check("rd_mem_adr", mem_adr, 32'h4);
    check("rd_mem_we", mem_we, 0);
    check("rd_mem_isel", mem_isel, 0);
    tick(); tick(); tick();
    check("rd_req_held", mem_req, 1);
    ack(32'h1234_5678);
    check("rd_valid", read_valid, 1);
    check("rd_req_drop", mem_req, 0);
    check("rd_data", read_data, 32'h1234_5678);
    tick();
    check("rd_valid_one_cycle", read_valid, 0);
    check("rd_data_held", read_data, 32'h1234_5678);

    // Simultaneous read and write: write goes first.
    u_read_req = 1; u_read_w = 1; u_read_adr = 32'h0000_0083;
    u_write_req = 1; u_write_w = 0; u_write_adr = 32'h0000_0200; u_write_data = 32'hA5A5_0001;
    tick();
    u_read_req = 0; u_write_req = 0;
    wait_sig(0, 10, seen);
    check("sim_wr_issued", seen, 1);
    check("sim_wr_we", mem_we, 1);
    check("sim_wr_adr", mem_adr, 32'h80);
    check("sim_wr_wdata", mem_wdata, 32'hA5A5_0001);
    tick();
    ack('0);
    check("sim_wr_finish", write_finish, 1);
    check("sim_wr_no_rvalid", read_valid, 0);
    tick();
    wait_sig(0, 10, seen);
    check("sim_rd_issued", seen, 1);
    check("sim_rd_we", mem_we, 0);
    check("sim_rd_isel", mem_isel, 1);
    check("sim_rd_adr", mem_adr, 32'h20);
    tick();
    ack(32'h0BAD_F00D);
    check("sim_rd_valid", read_valid, 1);
    check("sim_rd_data", read_data, 32'h0BAD_F00D);
    check("sim_no_ovr", req_ovr, 0);
    tick();

    // cpu_busy holds off a write to instruction memory for 20 cycles.
    cpu_busy = 1;
    tick(); tick();
    u_write_req = 1; u_write_w = 1; u_write_adr = 32'h0000_0100; u_write_data = 32'hCAFE_F00D;
    tick();
    u_write_req = 0;
    cnt = 0;
    for (int i = 0; i < 17; i++) begin
      if (mem_req) cnt++;
      tick();
    end
    check("busy_no_req", cnt, 0);
    cpu_busy = 0;
    wait_sig(0, 10, seen);
    check("busy_wr_issued", seen, 1);
    check("busy_wr_isel", mem_isel, 1);
    check("busy_wr_we", mem_we, 1);
    check("busy_wr_adr", mem_adr, 32'h40);
    cpu_busy = 1;
    tick();
    check("busy_no_abort", mem_req, 1);
    ack('0);
    check("busy_wr_finish", write_finish, 1);
    cpu_busy = 0;
    tick();

    // Overrun: second read while the first is in WAIT.
    pulse_rd(1'b0, 32'h0000_0040);
    wait_sig(0, 10, seen);
    check("ovr_first_issued", seen, 1);
    tick();
    pulse_rd(1'b0, 32'h0000_0044);
    check("ovr_flag", req_ovr, 1);
    check("ovr_adr_kept", mem_adr, 32'h10);
    ack(32'h1111_2222);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (read_valid) cnt++;
      if (mem_req) cnt += 100;
      tick();
    end
    check("ovr_one_valid", cnt, 1);
    check("ovr_data", read_data, 32'h1111_2222);

    // Reset mid-access.
    pulse_rd(1'b0, 32'h0000_0080);
    wait_sig(0, 10, seen);
    check("rstm_issued", seen, 1);
    tick();
    rst = 1;
    #1;
    check("rstm_req_drop", mem_req, 0);
    tick();
    rst = 0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (read_valid || mem_req) cnt++;
      tick();
    end
    check("rstm_no_completion", cnt, 0);
    check("rstm_ovr_clr", req_ovr, 0);
    check("rstm_data_clr", read_data, 0);

`ifdef BRIDGE_TIMEOUT_EN
    // Timeout: ISSUE plus 8 WAIT cycles of mem_req, then DEAD_BEEF.
    pulse_rd(1'b0, 32'h0000_00F0);
    wait_sig(0, 10, seen);
    check("to_issued", seen, 1);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (!mem_req) break;
      cnt++;
      tick();
    end
    check("to_req_cycles", cnt, 9);
    check("to_valid", read_valid, 1);
    check("to_data", read_data, 32'hDEAD_BEEF);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_mem_bridge.md
UART_MEM_BRIDGE -- requirements
Module: uart_mem_bridge

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 255, memory-ack timeout in clocks (range 1-65535).
REQ-002 Port: clk  in  1  sole clock, all state on rising edge.
REQ-003 Port: rst  in  1  asynchronous, active-high reset.
REQ-004 Port: u_read_req  in  1  one-cycle read request pulse from the UART monitor.
REQ-005 Port: u_read_w  in  1  read target select (1 = instruction memory, 0 = data memory).
REQ-006 Port: u_read_adr  in  32  read byte address; bits [1:0] ignored.
REQ-007 Port: read_valid  out  1  one-cycle pulse, read_data valid.
REQ-008 Port: read_data  out  32  last read word, held until the next read completes.
REQ-009 Port: u_write_req  in  1  one-cycle write request pulse.
REQ-010 Port: u_write_w  in  1  write target select (1 = instruction memory, 0 = data memory).
REQ-011 Port: u_write_adr  in  32  write byte address; bits [1:0] ignored.
REQ-012 Port: u_write_data  in  32  write word.
REQ-013 Port: write_finish  out  1  one-cycle pulse, write accepted by memory.
REQ-014 Port: cpu_busy  in  1  CPU owns memory; no new memory access is issued while high.
REQ-015 Port: mem_req  out  1  memory access request, held until mem_ack.
REQ-016 Port: mem_we  out  1  1 = write, 0 = read; stable while mem_req is high.
REQ-017 Port: mem_isel  out  1  1 = instruction memory, 0 = data memory; stable while mem_req is high.
REQ-018 Port: mem_adr  out  30  word address [31:2]; stable while mem_req is high.
REQ-019 Port: mem_wdata  out  32  write data; stable while mem_req is high.
REQ-020 Port: mem_ack  in  1  one-cycle completion; mem_rdata valid in the same cycle.
REQ-021 Port: mem_rdata  in  32  read data.
REQ-022 Port: req_ovr  out  1  sticky flag: a request was dropped.

Function
REQ-023 Request capture:
- A pulse on u_read_req or u_write_req latches select, address and data into that type's pending slot in the same cycle.
- One slot per type.
REQ-024 Overrun: a request arriving while its type's slot is occupied is dropped, the slot is unchanged, and req_ovr is set to 1.
REQ-025 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-026 IDLE -> ISSUE when any slot is pending and cpu_busy=0; if both slots are pending, the write is served first.
REQ-027 ISSUE:
- Drives mem_req=1 together with the registered mem_we, mem_isel, mem_adr and mem_wdata.
- Goes to WAIT in the next cycle.
- Total latency from request pulse to first mem_req cycle is 2 clocks when idle and cpu_busy=0.
REQ-028 WAIT: mem_req stays 1; on mem_ack the FSM captures mem_rdata for reads, clears the served slot, drops mem_req in the next cycle and goes to DONE.
REQ-029 DONE:
- Pulses read_valid or write_finish for exactly one cycle, then returns to IDLE.
- A pending slot is served no earlier than the following cycle.
REQ-030 cpu_busy rising during ISSUE or WAIT does not abort the access in flight.
REQ-031 A slot freed in the cycle DONE is entered accepts a new request that same cycle without overrun.
REQ-032 mem_ack received outside WAIT is ignored.

Reset
REQ-033 Reset state:
- FSM in IDLE; both slots empty.
- mem_req, mem_we, mem_isel, read_valid, write_finish, req_ovr = 0.
- read_data, mem_adr, mem_wdata = 0.
REQ-034 Reset asserted mid-access drops the access immediately: mem_req=0, and no completion pulse is produced after release.

Configuration
REQ-035 Macro BRIDGE_TIMEOUT_EN.
REQ-036 When defined:
- A 16-bit counter counts WAIT cycles.
- When it reaches TIMEOUT_CYC without mem_ack, the FSM drops mem_req, frees the slot and goes to DONE.
- A timed-out read returns read_data=32'hDEAD_BEEF.
REQ-037 When not defined: no counter is instantiated, and WAIT persists indefinitely until mem_ack.

Verification
REQ-038 Data read: u_read_req, u_read_w=0, adr 0x0000_0010, mem_ack with rdata 0x1234_5678 on the 3rd WAIT cycle -> mem_adr=0x4, mem_we=0, read_valid pulse, read_data=0x1234_5678.
REQ-039 Simultaneous requests: read and write pulsed in the same cycle -> write access issued first, write_finish, then read issued, read_valid; req_ovr=0.
REQ-040 cpu_busy gating: cpu_busy=1 for 20 cycles around a write request to instruction memory -> no mem_req until cpu_busy=0; then mem_isel=1, write_finish pulse.
REQ-041 Overrun: two read pulses 1 cycle apart while the first is still in WAIT -> second read dropped, req_ovr=1, only one read_valid.
REQ-042 Reset mid-access: rst asserted during WAIT -> mem_req=0 within the same cycle; no read_valid after release.
REQ-043 Timeout (BRIDGE_TIMEOUT_EN defined, TIMEOUT_CYC=8): read request with mem_ack never asserted -> mem_req drops after 8 WAIT cycles, read_valid pulses, read_data=0xDEAD_BEEF.
